// File: rtl/fifo_uart_tx.sv
// FIFO-fed UART transmitter: pops one byte per frame from a show-ahead FIFO
// and sends it LSB first as 8N1 / 8E1, with one or two stop bits.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_rdata,
  output logic       fifo_ren,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_PRE   = CW'(CLKS_PER_BIT - 2);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;
  logic          parity_bit, parity_n;
  logic          tx_n, ren_n, busy_n, done_n;
  logic          bit_end;

  assign bit_end = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      parity_bit <= 1'b0;
      tx         <= 1'b1;
      fifo_ren   <= 1'b0;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_idx_n;
      shift      <= shift_n;
      parity_bit <= parity_n;
      tx         <= tx_n;
      fifo_ren   <= ren_n;
      busy       <= busy_n;
      tx_done    <= done_n;
    end
  end

  // Outputs are computed one cycle ahead so every pin comes straight from a flop.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CW'(1);
    bit_idx_n = bit_idx;
    shift_n   = shift;
    parity_n  = parity_bit;
    tx_n      = tx;
    ren_n     = 1'b0;
    busy_n    = busy;
    done_n    = 1'b0;
    case (state)
      IDLE: begin
        cnt_n  = '0;
        tx_n   = 1'b1;
        busy_n = 1'b0;
        if (en && !fifo_empty) begin
          ren_n     = 1'b1;
          shift_n   = fifo_rdata;
          parity_n  = ^fifo_rdata;
          bit_idx_n = '0;
          tx_n      = 1'b0;
          busy_n    = 1'b1;
          state_n   = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          tx_n      = shift[0];
          state_n   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n = '0;
          if (bit_idx == 3'd7) begin
            bit_idx_n = '0;
            if (PARITY_EN != 0) begin
              tx_n    = parity_bit;
              state_n = PARITY;
            end else begin
              tx_n    = 1'b1;
              state_n = STOP;
            end
          end else begin
            shift_n   = {1'b0, shift[7:1]};
            tx_n      = shift[1];
            bit_idx_n = bit_idx + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          tx_n      = 1'b1;
          state_n   = STOP;
        end
      end
      STOP: begin
        tx_n = 1'b1;
        // tx_done must be visible during the final stop cycle, so raise it one cycle early.
        if (cnt == CNT_PRE && bit_idx == STOP_LAST) done_n = 1'b1;
        if (bit_end) begin
          cnt_n = '0;
          if (bit_idx == STOP_LAST) begin
            bit_idx_n = '0;
            busy_n    = 1'b0;
            state_n   = IDLE;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end
      end
      default: begin
        cnt_n     = '0;
        bit_idx_n = '0;
        tx_n      = 1'b1;
        busy_n    = 1'b0;
        state_n   = IDLE;
      end
    endcase
  end

endmodule
